// File: rtl/countdown_timer_99_if.sv
// Control/status bundle for the 0..99 countdown timer.
// master drives controls; slave (the timer) drives status.
interface countdown_timer_99_if;
  logic       load;
  logic [6:0] load_val;
  logic       start;
  logic       pause;
  logic [6:0] count;
  logic       running;
  logic       expired;
  logic       done;

  modport master (
    output load, load_val, start, pause,
    input  count, running, expired, done
  );

  modport slave (
    input  load, load_val, start, pause,
    output count, running, expired, done
  );
endinterface

// File: rtl/countdown_timer_99.sv
// Seconds-style 0..99 countdown with load, start, pause/resume, expiry.
// count feeds the downstream binary-to-BCD converter directly.
module countdown_timer_99 #(
  parameter int TICK_DIV = 100000000,
  parameter int PRE_W    = 27
) (
  input  logic                  clk,
  input  logic                  rst_n,
  countdown_timer_99_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSED,
    S_EXPIRED
  } state_t;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  state_t           state_q, state_d;
  logic [6:0]       count_q, count_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             running_q, running_d;
  logic             expired_q, expired_d;
  logic             done_q, done_d;

  logic go, stop;

  // start and pause together cancel each other out
  assign go   = bus.start & ~bus.pause;
  assign stop = bus.pause & ~bus.start;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    pre_d   = pre_q;
    done_d  = 1'b0;
    if (bus.load) begin
      count_d = (bus.load_val > 7'd99) ? 7'd99 : bus.load_val;
      pre_d   = '0;
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (go && count_q != 7'd0) begin
            state_d = S_RUN;
            pre_d   = '0;
          end
        end
        S_RUN: begin
          if (stop) begin
            state_d = S_PAUSED;
          end else if (pre_q == PRE_LAST) begin
            pre_d = '0;
            if (count_q != 7'd0) begin
              count_d = count_q - 7'd1;
            end
            if (count_q == 7'd1) begin
              state_d = S_EXPIRED;
              done_d  = 1'b1;
            end
          end else begin
            pre_d = pre_q + 1'b1;
          end
        end
        S_PAUSED: begin
          if (go) begin
            state_d = S_RUN;
          end
        end
        S_EXPIRED: begin
          count_d = 7'd0;
        end
        default: state_d = S_IDLE;
      endcase
    end
    running_d = (state_d == S_RUN);
    expired_d = (state_d == S_EXPIRED);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      pre_q     <= '0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      pre_q     <= pre_d;
      running_q <= running_d;
      expired_q <= expired_d;
      done_q    <= done_d;
    end
  end

  assign bus.count   = count_q;
  assign bus.running = running_q;
  assign bus.expired = expired_q;
  assign bus.done    = done_q;

endmodule
